dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data memory between the core load-store path
//   (port 0) and a secondary bus master (port 1: debug/DMA loader).
//   Issues at most one memory command per cycle and routes read data back
//   to the issuing port after the fixed memory read latency.
//   Arbitration is fixed priority to port 0, with a starvation counter that
//   forces one port 1 grant. Sits between the LSU/loader and the dmem macro.
// PARAMETERS
//   XLEN         32  data width (bits)
//   ADDR_W       32  address width (bits)
//   MEM_LATENCY  1   cycles from accepted read to valid i_mem_rdata (1..4)
//   STARVE_MAX   4   port-1 losing cycles before port 1 gets priority (1..15)
// PORTS
//   i_clk         in   1          clock, rising edge
//   i_rst_n       in   1          synchronous reset, active low
//   i_req[1:0]    in   2          per-port request
//   i_we[1:0]     in   2          per-port write enable (0 = read)
//   i_addr[p]     in   ADDR_W     per-port byte address (memory-relative)
//   i_wdata[p]    in   XLEN       per-port write data
//   i_wstrb[p]    in   XLEN/8     per-port byte strobes
//   o_gnt[1:0]    out  2          command accepted this cycle (one-hot or 0)
//   o_rvalid[1:0] out  2          read data valid for that port
//   o_rdata       out  XLEN       read data (qualified by o_rvalid)
//   o_mem_en      out  1          memory command strobe
//   o_mem_we      out  1          memory write enable
//   o_mem_addr    out  ADDR_W     memory address
//   o_mem_wdata   out  XLEN       memory write data
//   o_mem_wstrb   out  XLEN/8     memory byte strobes
//   i_mem_rdata   in   XLEN       memory read data
// BEHAVIOUR
//   - Grant is combinational from i_req and priority state; a port's
//     command is accepted in the cycle o_gnt[p]=1. Requester holds
//     req/we/addr/wdata/wstrb stable until granted.
//   - o_mem_* mirror the granted port's command in the same cycle;
//     o_mem_en = |o_gnt. No grant: o_mem_en=0, o_mem_we=0, o_mem_wstrb=0,
//     addr/wdata = port 0 inputs (don't-care).
//   - o_mem_we and o_mem_wstrb are forced to 0 on read commands.
//   - Priority FSM: PRIO_P0 (reset) and PRIO_P1.
//     PRIO_P0: both request -> grant port 0; starve_cnt increments when
//       port 1 requests and is not granted, clears when port 1 is granted or
//       not requesting. starve_cnt reaching STARVE_MAX -> PRIO_P1 next cycle.
//     PRIO_P1: port 1 granted if requesting (port 0 if only port 0);
//       return to PRIO_P0 after any grant to port 1, or if port 1 drops req.
//       starve_cnt cleared on entry to PRIO_P0.
//   - starve_cnt is 4 bits and saturates; it never wraps.
//   - Read return: a MEM_LATENCY-deep shift register of {valid, port id}.
//     An accepted read enters the register. o_rvalid[id] is asserted exactly
//     MEM_LATENCY cycles after the grant. o_rdata = i_mem_rdata.
//     Writes produce no o_rvalid.
//   - Back-to-back reads from either port: one per cycle, fully pipelined.
//     Returns arrive in issue order. Port 0 read then port 1 read in
//     consecutive cycles -> rvalid 2'b01 then 2'b10.
//   - Reset (i_rst_n=0 at a rising edge): FSM to PRIO_P0, starve_cnt=0,
//     return pipeline cleared. During reset o_gnt=0, o_mem_en=0, and
//     o_rvalid=0. In-flight reads are dropped (no rvalid after reset).
//   - o_gnt never asserts for a port with i_req=0; |o_rvalid <= 1 bit set.
// TESTING
//   1 Single read: P0 req, we=0, addr=0x40, i_mem_rdata=0xDEADBEEF
//     (latency 1) -> gnt=01 in cycle 0; rvalid=01 with rdata=0xDEADBEEF in cycle 1.
//   2 Single write: P1 req, we=1, addr=0x10, wdata=0x12345678, wstrb=0011
//     -> gnt=10; mem_we=1; mem_wstrb=0011; mem_addr=0x10; no rvalid.
//   3 Contention: both ports request reads continuously, STARVE_MAX=4
//     -> gnt sequence 01,01,01,01,10,01,...; port 1 granted every 5th cycle.
//   4 Pipelined returns: MEM_LATENCY=2; reads P0,P1,P0 in consecutive cycles
//     -> rvalid 01,10,01 on cycles 2,3,4 with matching rdata.
//   5 Reset mid-flight: P0 read granted; i_rst_n=0 on the next edge
//     -> no rvalid, FSM PRIO_P0, starve_cnt=0 after release.
//   6 Idle/drop: P1 starving (cnt=3), then P1 deasserts req
//     -> cnt clears; next P1 request waits STARVE_MAX more losses.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: fixed priority to
// port 0 with a starvation escape for port 1, plus in-order read-return routing.
module dmem_arbiter #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [1:0]                  i_req,
    input  logic [1:0]                  i_we,
    input  logic [1:0][ADDR_W-1:0]      i_addr,
    input  logic [1:0][XLEN-1:0]        i_wdata,
    input  logic [1:0][XLEN/8-1:0]      i_wstrb,
    output logic [1:0]                  o_gnt,
    output logic [1:0]                  o_rvalid,
    output logic [XLEN-1:0]             o_rdata,
    output logic                        o_mem_en,
    output logic                        o_mem_we,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic [XLEN-1:0]             o_mem_wdata,
    output logic [XLEN/8-1:0]           o_mem_wstrb,
    input  logic [XLEN-1:0]             i_mem_rdata
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        PRIO_P0 = 1'b0,
        PRIO_P1 = 1'b1
    } prio_e;

    typedef struct packed {
        logic valid;
        logic id;
    } ret_t;

    prio_e                      state_q, state_d;
    logic [CNT_W-1:0]           starve_q, starve_d;
    ret_t [MEM_LATENCY-1:0]     pipe_q, pipe_d;
    logic [1:0]                 gnt_c;
    logic                       gnt_id;

    // Grant: port 1 wins only during its one-cycle priority window
    always_comb begin
        gnt_c = 2'b00;
        if (i_rst_n) begin
            if (state_q == PRIO_P1 && i_req[1]) begin
                gnt_c = 2'b10;
            end else if (i_req[0]) begin
                gnt_c = 2'b01;
            end else if (i_req[1]) begin
                gnt_c = 2'b10;
            end
        end
    end

    assign gnt_id = gnt_c[1];

    // Memory command mirrors the granted port; idle selects port 0's fields
    always_comb begin
        o_gnt       = gnt_c;
        o_mem_en    = |gnt_c;
        o_mem_addr  = i_addr[gnt_id];
        o_mem_wdata = i_wdata[gnt_id];
        o_mem_we    = o_mem_en & i_we[gnt_id];
        o_mem_wstrb = o_mem_we ? i_wstrb[gnt_id] : '0;
    end

    // Priority FSM and starvation counter next state
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            PRIO_P0: begin
                if (i_req[1] && !gnt_c[1]) begin
                    starve_d = (starve_q == '1) ? starve_q : starve_q + CNT_W'(1);
                    if (starve_d >= CNT_W'(STARVE_MAX)) begin
                        state_d = PRIO_P1;
                    end
                end else begin
                    starve_d = '0;
                end
            end
            // Port 1 is either granted or has dropped its request: window closes
            PRIO_P1: begin
                state_d  = PRIO_P0;
                starve_d = '0;
            end
            default: begin
                state_d  = PRIO_P0;
                starve_d = '0;
            end
        endcase
    end

    // Read-return shift register: accepted reads enter, shift one stage per cycle
    always_comb begin
        pipe_d          = pipe_q;
        pipe_d[0].valid = o_mem_en & ~o_mem_we;
        pipe_d[0].id    = gnt_id;
        for (int i = 1; i < int'(MEM_LATENCY); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= PRIO_P0;
            starve_q <= '0;
            pipe_q   <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            pipe_q   <= pipe_d;
        end
    end

    always_comb begin
        o_rvalid = 2'b00;
        if (i_rst_n && pipe_q[MEM_LATENCY-1].valid) begin
            o_rvalid = pipe_q[MEM_LATENCY-1].id ? 2'b10 : 2'b01;
        end
        o_rdata = i_mem_rdata;
    end

endmodule
